// File: rtl/ml_rowdrv_pkg.sv
// Shared types and constants for the CRAM row-driver bank.
// Covers the sequencer states, the latched operation and the RSR shift directions.
package ml_rowdrv_pkg;

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StRecov} state_e;

  typedef enum logic {OpWr, OpRd} op_e;

  // DirUp enters at row 0 and moves toward row N-1; DirDown is the mirror image.
  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ml_rsr_chain.sv
// Row shift register: bidirectional serial shift, parallel load and a freeze input.
// When both are requested in the same cycle, the parallel load takes priority over the shift.
module ml_rsr_chain
  import ml_rowdrv_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                load,
  input  logic [NUM_ROWS-1:0] load_val,
  input  logic                shift,
  input  logic                dir,
  input  logic                sin,
  output logic [NUM_ROWS-1:0] rsr,
  output logic                sout
);

  logic [NUM_ROWS-1:0] rsr_q, rsr_d;

  always_comb begin
    rsr_d = rsr_q;
    if (!freeze) begin
      if (load) begin
        rsr_d = load_val;
      end else if (shift) begin
        rsr_d = (dir == DirUp) ? {rsr_q[NUM_ROWS-2:0], sin} : {sin, rsr_q[NUM_ROWS-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsr_q <= '0;
    end else begin
      rsr_q <= rsr_d;
    end
  end

  assign rsr  = rsr_q;
  assign sout = (dir == DirUp) ? rsr_q[NUM_ROWS-1] : rsr_q[0];

endmodule

// File: rtl/ml_rowdrv_bank.sv
// CRAM row-driver bank: RSR, per-row gated controls and a setup/pulse/recovery
// word-line sequencer with a req/done handshake.
module ml_rowdrv_bank
  import ml_rowdrv_pkg::*;
#(
  parameter int unsigned NUM_ROWS  = 16,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 8,
  parameter int unsigned RECOV_CYC = 2,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic                smc_clk,
  input  logic                rsr_rst,
  input  logic                por_rst,
  input  logic                smc_rsr_in,
  input  logic                smc_rsr_inc,
  input  logic                smc_rsr_dir,
  input  logic                smc_rsr_load,
  input  logic [NUM_ROWS-1:0] smc_rsr_load_val,
  output logic                smc_rsr_out,
  output logic [NUM_ROWS-1:0] rsr_q,
  input  logic                cram_rst,
  input  logic                cram_vddoff,
  input  logic                cram_pgateoff,
  input  logic                cram_wl_en,
  input  logic                smc_wr_req,
  input  logic                smc_rd_req,
  output logic                smc_busy,
  output logic                smc_done,
  output logic [NUM_ROWS-1:0] wl_wr,
  output logic [NUM_ROWS-1:0] wl_rd,
  output logic                wl_rden_b,
  output logic [NUM_ROWS-1:0] reset,
  output logic [NUM_ROWS-1:0] vddctrl,
  output logic [NUM_ROWS-1:0] pgate
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, RECOV_CYC) + 1);

  // Counters load *_CYC-1 on phase entry and the phase ends on the cycle they read zero.
  localparam logic [CNT_W-1:0] SetupLd = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PulseLd = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RecovLd = CNT_W'(RECOV_CYC - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                done_q, done_d;
  logic                adv;
  logic [NUM_ROWS-1:0] rsr;
  logic [NUM_ROWS-1:0] wl_wr_q, wl_wr_d, wl_rd_q, wl_rd_d;
  logic                wl_rden_b_q;
  logic [NUM_ROWS-1:0] reset_q, vddctrl_q, pgate_q;
  logic                chain_freeze, chain_shift, chain_load, chain_sin;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((smc_wr_req | smc_rd_req) & cram_wl_en) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          op_d    = smc_wr_req ? OpWr : OpRd;
          abort_d = 1'b0;
        end
      end
      StSetup: begin
        if (!cram_wl_en) begin
          state_d = StRecov;
          cnt_d   = RecovLd;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StPulse: begin
        if (!cram_wl_en || cnt_q == '0) begin
          state_d = StRecov;
          cnt_d   = RecovLd;
          abort_d = ~cram_wl_en;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRecov: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          adv     = AUTO_INC && (op_q == OpWr) && !abort_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (por_rst) begin
      state_d = StIdle;
      done_d  = 1'b0;
      adv     = 1'b0;
    end
  end

  // The RSR is only free to move while idle, apart from the post-write auto-advance edge.
  always_comb begin
    chain_freeze = por_rst | ((state_q != StIdle) & ~adv);
    chain_load   = smc_rsr_load & ~adv;
    chain_shift  = smc_rsr_inc | adv;
    chain_sin    = adv ? 1'b0 : smc_rsr_in;
  end

  ml_rsr_chain #(
    .NUM_ROWS (NUM_ROWS)
  ) u_chain (
    .clk      (smc_clk),
    .rst      (rsr_rst),
    .freeze   (chain_freeze),
    .load     (chain_load),
    .load_val (smc_rsr_load_val),
    .shift    (chain_shift),
    .dir      (smc_rsr_dir),
    .sin      (chain_sin),
    .rsr      (rsr),
    .sout     (smc_rsr_out)
  );

  // Word lines follow the next state so they are high exactly while the FSM sits in PULSE.
  always_comb begin
    wl_wr_d = '0;
    wl_rd_d = '0;
    if (state_d == StPulse) begin
      if (op_q == OpWr) begin
        wl_wr_d = rsr;
      end else begin
        wl_rd_d = rsr;
      end
    end
  end

  always_ff @(posedge smc_clk) begin
    if (rsr_rst) begin
      state_q     <= StIdle;
      op_q        <= OpWr;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      wl_wr_q     <= '0;
      wl_rd_q     <= '0;
      wl_rden_b_q <= 1'b1;
      reset_q     <= '0;
      vddctrl_q   <= '0;
      pgate_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      wl_wr_q     <= wl_wr_d;
      wl_rd_q     <= wl_rd_d;
      wl_rden_b_q <= ~|wl_rd_d;
      reset_q     <= (rsr & {NUM_ROWS{cram_rst}}) | {NUM_ROWS{por_rst}};
      vddctrl_q   <= rsr & {NUM_ROWS{cram_vddoff}};
      pgate_q     <= rsr & {NUM_ROWS{cram_pgateoff}};
    end
  end

  assign rsr_q     = rsr;
  assign smc_busy  = (state_q != StIdle);
  assign smc_done  = done_q;
  assign wl_wr     = wl_wr_q;
  assign wl_rd     = wl_rd_q;
  assign wl_rden_b = wl_rden_b_q;
  assign reset     = reset_q;
  assign vddctrl   = vddctrl_q;
  assign pgate     = pgate_q;

endmodule
